control_interlock: RTL and testbench

Hazard-detection interlock for the team's 5-stage in-order RV32I pipeline, which has no forwarding.
- Decodes which source registers the instruction in IF/ID actually reads, from its opcode.
- Compares them against the destination registers of the in-flight writers in ID/EXE, EXE/MEM and MEM/WB.
- Asserts stall while any read-after-write hazard exists.
- Also reports which stage caused the hazard and keeps a stall-cycle performance counter.

---
 rtl/rv_pkg.sv | 48 ++++
 rtl/rs_usage_decode.sv | 27 ++
 rtl/control_interlock.sv | 115 +++++++++++
 tb/tb_control_interlock.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared RV32I definitions for the pipeline control blocks (interlock and
// forwarding unit). Holds the major-opcode encodings, the architectural
// register-address width and a small helper that classifies opcodes.
// No ports: package only.
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  // Source-operand usage of one instruction.
  typedef struct packed {
    logic rs1;
    logic rs2;
  } rs_use_t;

  // Maps a major opcode to the register-file ports it reads. Opcodes that
  // read nothing (JAL, AUIPC, LUI, FENCE, SYSTEM, bubble, unknown) fall
  // through to the all-zero default so they can never stall.
  function automatic rs_use_t opcode_rs_use(input logic [6:0] opcode);
    rs_use_t u;
    u = '0;
    case (opcode)
      R_TYPE: u = '{rs1: 1'b1, rs2: 1'b1};
      STORE:  u = '{rs1: 1'b1, rs2: 1'b1};
      BRANCH: u = '{rs1: 1'b1, rs2: 1'b1};
      I_TYPE: u = '{rs1: 1'b1, rs2: 1'b0};
      LOAD:   u = '{rs1: 1'b1, rs2: 1'b0};
      JALR:   u = '{rs1: 1'b1, rs2: 1'b0};
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/rs_usage_decode.sv
// ---------------------------------------------------------------------------
// rs_usage_decode
// Decodes which source registers the instruction actually reads from its
// major opcode. Purely combinational; shared by the interlock and the
// forwarding unit so both agree on operand usage.
// Ports:
//   opcode   in  7  major opcode field of the instruction
//   use_rs1  out 1  instruction reads rs1
//   use_rs2  out 1  instruction reads rs2
// ---------------------------------------------------------------------------
module rs_usage_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       use_rs1,
  output logic       use_rs2
);

  rs_use_t use_dec;

  always_comb begin
    use_dec = opcode_rs_use(opcode);
    use_rs1 = use_dec.rs1;
    use_rs2 = use_dec.rs2;
  end

endmodule

// File: rtl/control_interlock.sv
// ---------------------------------------------------------------------------
// control_interlock
// Read-after-write hazard interlock for the 5-stage in-order RV32I pipeline
// (no forwarding). The instruction in IF/ID is compared against the
// destinations of the writers in ID/EXE, EXE/MEM and MEM/WB; any match on a
// source the opcode really reads requests a stall. A saturating counter
// records how many cycles were lost to stalls.
// Parameters:
//   REG_AW     register-address width
//   WB_BYPASS  1 = write-before-read register file, MEM/WB never hazards
//   CNT_W      width of the stall-cycle counter
// Ports:
//   clock, reset                          clock (rising edge), sync reset
//   id_exe_regWrite / id_exe_write_reg    writer in EXE
//   exe_mem_regWrite / exe_mem_write_reg  writer in MEM
//   mem_wb_regWrite / mem_wb_write_reg    writer in WB
//   if_id_opcode, if_id_read_reg1/2       instruction in ID
//   stall       out  combinational stall request
//   hazard_src  out  combinational {mem_wb, exe_mem, id_exe} match bits
//   stall_count out  registered saturating count of stalled cycles
// ---------------------------------------------------------------------------
module control_interlock #(
  parameter int REG_AW    = rv_pkg::REG_AW,
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_exe_regWrite,
  input  logic [REG_AW-1:0] id_exe_write_reg,
  input  logic              exe_mem_regWrite,
  input  logic [REG_AW-1:0] exe_mem_write_reg,
  input  logic              mem_wb_regWrite,
  input  logic [REG_AW-1:0] mem_wb_write_reg,
  input  logic [6:0]        if_id_opcode,
  input  logic [REG_AW-1:0] if_id_read_reg1,
  input  logic [REG_AW-1:0] if_id_read_reg2,
  output logic              stall,
  output logic [2:0]        hazard_src,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int NUM_STAGES = 3;

  // A single in-flight writer conflicts with the ID instruction when it
  // really writes, its destination is not x0, and it names a source the
  // opcode actually reads.
  function automatic logic stage_match(
    input logic              reg_write,
    input logic [REG_AW-1:0] write_reg,
    input logic              use_rs1,
    input logic              use_rs2,
    input logic [REG_AW-1:0] read_reg1,
    input logic [REG_AW-1:0] read_reg2
  );
    logic hit1;
    logic hit2;
    hit1 = use_rs1 && (write_reg == read_reg1);
    hit2 = use_rs2 && (write_reg == read_reg2);
    return reg_write && (write_reg != '0) && (hit1 || hit2);
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (&val) begin
      return val;
    end
    return val + CNT_W'(1);
  endfunction

  logic                    use_rs1;
  logic                    use_rs2;
  logic [NUM_STAGES-1:0]   stage_we;
  logic [REG_AW-1:0]       stage_wd [NUM_STAGES];
  logic [NUM_STAGES-1:0]   stage_hit;
  logic [CNT_W-1:0]        stall_count_p1;

  rs_usage_decode u_rs_usage_decode (
    .opcode  (if_id_opcode),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  // Index order matches hazard_src: 0 = ID/EXE, 1 = EXE/MEM, 2 = MEM/WB.
  assign stage_we    = {mem_wb_regWrite, exe_mem_regWrite, id_exe_regWrite};
  assign stage_wd[0] = id_exe_write_reg;
  assign stage_wd[1] = exe_mem_write_reg;
  assign stage_wd[2] = mem_wb_write_reg;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    assign stage_hit[g] = stage_match(stage_we[g], stage_wd[g],
                                      use_rs1, use_rs2,
                                      if_id_read_reg1, if_id_read_reg2);
  end

  // With a write-before-read register file the WB writer's value is already
  // visible to the ID read, so MEM/WB can never be a hazard.
  always_comb begin
    hazard_src    = stage_hit;
    hazard_src[2] = WB_BYPASS ? 1'b0 : stage_hit[2];
    stall         = |hazard_src;
  end

  // Stage p1: stall-cycle counter, reset has priority over a concurrent stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_p1 <= '0;
    end else if (stall) begin
      stall_count_p1 <= sat_inc(stall_count_p1);
    end
  end

  assign stall_count = stall_count_p1;

endmodule

// File: tb/tb_control_interlock.sv
module tb_control_interlock;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_UNK    = 7'b1111111;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_exe_regWrite, exe_mem_regWrite, mem_wb_regWrite;
  logic [4:0] id_exe_write_reg, exe_mem_write_reg, mem_wb_write_reg;
  logic [6:0] if_id_opcode;
  logic [4:0] if_id_read_reg1, if_id_read_reg2;

  logic        stall_a, stall_b;
  logic [2:0]  src_a, src_b;
  logic [31:0] cnt_a;
  logic [2:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Default build: WB hazards checked, 32-bit counter.
  control_interlock #(.REG_AW(5), .WB_BYPASS(1'b0), .CNT_W(32)) dut_a (
    .clock(clock), .reset(reset),
    .id_exe_regWrite(id_exe_regWrite), .id_exe_write_reg(id_exe_write_reg),
    .exe_mem_regWrite(exe_mem_regWrite), .exe_mem_write_reg(exe_mem_write_reg),
    .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_write_reg(mem_wb_write_reg),
    .if_id_opcode(if_id_opcode),
    .if_id_read_reg1(if_id_read_reg1), .if_id_read_reg2(if_id_read_reg2),
    .stall(stall_a), .hazard_src(src_a), .stall_count(cnt_a)
  );

  // Bypass build with a 3-bit counter so saturation is reachable quickly.
  control_interlock #(.REG_AW(5), .WB_BYPASS(1'b1), .CNT_W(3)) dut_b (
    .clock(clock), .reset(reset),
    .id_exe_regWrite(id_exe_regWrite), .id_exe_write_reg(id_exe_write_reg),
    .exe_mem_regWrite(exe_mem_regWrite), .exe_mem_write_reg(exe_mem_write_reg),
    .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_write_reg(mem_wb_write_reg),
    .if_id_opcode(if_id_opcode),
    .if_id_read_reg1(if_id_read_reg1), .if_id_read_reg2(if_id_read_reg2),
    .stall(stall_b), .hazard_src(src_b), .stall_count(cnt_b)
  );

  task automatic set_writers(input logic w0, input logic [4:0] d0,
                             input logic w1, input logic [4:0] d1,
                             input logic w2, input logic [4:0] d2);
    id_exe_regWrite  = w0; id_exe_write_reg  = d0;
    exe_mem_regWrite = w1; exe_mem_write_reg = d1;
    mem_wb_regWrite  = w2; mem_wb_write_reg  = d2;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [4:0] r1,
                           input logic [4:0] r2);
    if_id_opcode = op; if_id_read_reg1 = r1; if_id_read_reg2 = r2;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_writers(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    set_instr(7'd0, 5'd0, 5'd0);
    repeat (2) @(negedge clock);
    checks++;
    if (cnt_a !== 32'd0) begin errors++; $display("FAIL reset_cnt_a got %0d exp 0", cnt_a); end
    checks++;
    if (cnt_b !== 3'd0) begin errors++; $display("FAIL reset_cnt_b got %0d exp 0", cnt_b); end
    reset = 1'b0;
  endtask

  task automatic test_idle;
    set_writers(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    set_instr(7'd0, 5'd0, 5'd0);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL idle_stall got %b exp 0", stall_a); end
    checks++;
    if (src_a !== 3'b000) begin errors++; $display("FAIL idle_src got %b exp 000", src_a); end
  endtask

  task automatic test_exe_hazard;
    set_writers(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    set_instr(OP_R, 5'd1, 5'd3);
    checks++;
    if (stall_a !== 1'b1) begin errors++; $display("FAIL exe_stall got %b exp 1", stall_a); end
    checks++;
    if (src_a !== 3'b001) begin errors++; $display("FAIL exe_src got %b exp 001", src_a); end
    // rs2 side of an R-type against ID/EXE, rs1 side against EXE/MEM
    set_writers(1'b1, 5'd4, 1'b1, 5'd9, 1'b0, 5'd0);
    set_instr(OP_R, 5'd9, 5'd4);
    checks++;
    if (src_a !== 3'b011) begin errors++; $display("FAIL exe_mem_both_src got %b exp 011", src_a); end
  endtask

  task automatic test_mem_rs2;
    set_writers(1'b0, 5'd0, 1'b1, 5'd10, 1'b0, 5'd0);
    set_instr(OP_BRANCH, 5'd2, 5'd10);
    checks++;
    if (stall_a !== 1'b1) begin errors++; $display("FAIL mem_rs2_stall got %b exp 1", stall_a); end
    checks++;
    if (src_a !== 3'b010) begin errors++; $display("FAIL mem_rs2_src got %b exp 010", src_a); end
    // regWrite low on a matching destination must not stall
    set_writers(1'b0, 5'd10, 1'b0, 5'd10, 1'b0, 5'd10);
    set_instr(OP_BRANCH, 5'd10, 5'd10);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL no_regwrite_stall got %b exp 0", stall_a); end
  endtask

  task automatic test_unused_field;
    set_writers(1'b0, 5'd0, 1'b1, 5'd10, 1'b0, 5'd0);
    set_instr(OP_I, 5'd2, 5'd10);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL itype_rs2_stall got %b exp 0", stall_a); end
    set_instr(OP_LUI, 5'd10, 5'd0);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL lui_stall got %b exp 0", stall_a); end
    set_instr(OP_JAL, 5'd10, 5'd10);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL jal_stall got %b exp 0", stall_a); end
    set_instr(OP_AUIPC, 5'd10, 5'd10);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL auipc_stall got %b exp 0", stall_a); end
    set_instr(OP_FENCE, 5'd10, 5'd10);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL fence_stall got %b exp 0", stall_a); end
    set_instr(OP_SYSTEM, 5'd10, 5'd10);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL system_stall got %b exp 0", stall_a); end
    set_instr(OP_UNK, 5'd10, 5'd10);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL unknown_stall got %b exp 0", stall_a); end
    // I-type does read rs1
    set_instr(OP_I, 5'd10, 5'd0);
    checks++;
    if (src_a !== 3'b010) begin errors++; $display("FAIL itype_rs1_src got %b exp 010", src_a); end
  endtask

  task automatic test_x0;
    set_writers(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    set_instr(OP_R, 5'd0, 5'd0);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL x0_stall got %b exp 0", stall_a); end
    checks++;
    if (src_a !== 3'b000) begin errors++; $display("FAIL x0_src got %b exp 000", src_a); end
  endtask

  task automatic test_wb;
    set_writers(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    set_instr(OP_STORE, 5'd6, 5'd5);
    checks++;
    if (stall_a !== 1'b1) begin errors++; $display("FAIL wb_stall got %b exp 1", stall_a); end
    checks++;
    if (src_a !== 3'b100) begin errors++; $display("FAIL wb_src got %b exp 100", src_a); end
    checks++;
    if (stall_b !== 1'b0) begin errors++; $display("FAIL wb_bypass_stall got %b exp 0", stall_b); end
    checks++;
    if (src_b !== 3'b000) begin errors++; $display("FAIL wb_bypass_src got %b exp 000", src_b); end
  endtask

  task automatic test_multi;
    set_writers(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7);
    set_instr(OP_JALR, 5'd7, 5'd0);
    checks++;
    if (src_a !== 3'b111) begin errors++; $display("FAIL multi_src got %b exp 111", src_a); end
    checks++;
    if (src_b !== 3'b011) begin errors++; $display("FAIL multi_bypass_src got %b exp 011", src_b); end
    checks++;
    if (stall_b !== 1'b1) begin errors++; $display("FAIL multi_bypass_stall got %b exp 1", stall_b); end
  endtask

  task automatic test_counter;
    @(negedge clock);
    reset = 1'b1;
    set_writers(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    set_instr(7'd0, 5'd0, 5'd0);
    @(negedge clock);
    reset = 1'b0;
    // idle cycles do not count
    repeat (2) @(negedge clock);
    checks++;
    if (cnt_a !== 32'd0) begin errors++; $display("FAIL cnt_idle got %0d exp 0", cnt_a); end
    set_writers(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    set_instr(OP_R, 5'd1, 5'd3);
    repeat (3) @(negedge clock);
    checks++;
    if (cnt_a !== 32'd3) begin errors++; $display("FAIL cnt_three got %0d exp 3", cnt_a); end
    // reset while stalling wins
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (cnt_a !== 32'd0) begin errors++; $display("FAIL cnt_reset_wins got %0d exp 0", cnt_a); end
    checks++;
    if (stall_a !== 1'b1) begin errors++; $display("FAIL stall_during_reset got %b exp 1", stall_a); end
    reset = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (cnt_a !== 32'd10) begin errors++; $display("FAIL cnt_ten got %0d exp 10", cnt_a); end
    checks++;
    if (cnt_b !== 3'd7) begin errors++; $display("FAIL cnt_saturate got %0d exp 7", cnt_b); end
    // release stall: both counters hold
    set_instr(7'd0, 5'd0, 5'd0);
    repeat (2) @(negedge clock);
    checks++;
    if (cnt_a !== 32'd10) begin errors++; $display("FAIL cnt_hold got %0d exp 10", cnt_a); end
    checks++;
    if (cnt_b !== 3'd7) begin errors++; $display("FAIL cnt_sat_hold got %0d exp 7", cnt_b); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_exe_hazard();
    test_mem_rs2();
    test_unused_field();
    test_x0();
    test_wb();
    test_multi();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
